hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that produces the stall, flush and forwarding controls consumed by the F/D, D/E (clr), E/M and M/W pipeline registers.
- Detects load-use hazards, taken branches/jumps, and data-memory wait states.
- Holds a small FSM for memory-wait tracking with a watchdog timeout.
- Holds saturating performance counters for stall and flush cycles.

Parameters:
- REG_WIDTH, 5, register-address width.
- CNT_WIDTH, 16, width of each performance counter.
- MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- rs1_d  in  REG_WIDTH  source reg 1 of the instruction in Decode.
- rs2_d  in  REG_WIDTH  source reg 2 of the instruction in Decode.
- rs1_e  in  REG_WIDTH  source reg 1 of the instruction in Execute.
- rs2_e  in  REG_WIDTH  source reg 2 of the instruction in Execute.
- rd_e  in  REG_WIDTH  destination reg in Execute.
- result_src_e  in  2  result select in Execute; 2'b01 = load.
- pc_src_e  in  1  branch taken / jump resolved in Execute.
- rd_m  in  REG_WIDTH  destination reg in Memory.
- reg_write_m  in  1  Memory-stage write enable.
- rd_w  in  REG_WIDTH  destination reg in Writeback.
- reg_write_w  in  1  Writeback-stage write enable.
- mem_req_m  in  1  Memory stage issuing a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold F/D register.
- flush_d  out  1  clear F/D register.
- flush_e  out  1  clr to D/E register.
- freeze  out  1  hold all pipeline registers (memory wait).
- forward_a_e  out  2  ALU operand A select.
- forward_b_e  out  2  ALU operand B select.
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt  out  CNT_WIDTH  cycles with stall_f or freeze asserted.
- flush_cnt  out  CNT_WIDTH  cycles with flush_d asserted.

Behaviour:
- Reset (async, rst=1):
  - State = RUN; wait counter, stall_cnt, flush_cnt and mem_timeout = 0.
  - While rst is high, combinational outputs are forced: stall_f, stall_d and freeze = 0; flush_d and flush_e = 1; forward_* = 00.
- Forwarding (combinational), applied to rs1_e → forward_a_e and to rs2_e → forward_b_e:
  - 2'b10 if reg_write_m, rd_m != 0 and rd_m == rs.
  - Otherwise 2'b01 if reg_write_w, rd_w != 0 and rd_w == rs.
  - Otherwise 2'b00. Memory stage has priority over Writeback.
- Load-use: lw = (result_src_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).
- Branch: br = pc_src_e.
- Freeze (combinational): freeze = mem_req_m && !mem_ready.
- Normal outputs when freeze = 0:
  - stall_f = stall_d = lw && !br; flush wins over stall when both hazards coincide.
  - flush_d = br.
  - flush_e = lw || br.
- Outputs when freeze = 1:
  - stall_f, stall_d, flush_d and flush_e are all 0; the whole pipe holds, and the pending branch or load-use is re-evaluated on release.
  - forward_* still follow the rules above.
- FSM:
  - RUN → MEM_WAIT when freeze = 1 at a clock edge.
  - MEM_WAIT → RUN on the edge where mem_ready = 1 or mem_req_m = 0.
  - The wait counter clears on entry to MEM_WAIT and increments each cycle spent in MEM_WAIT.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout sets and stays set until rst. The FSM stays in MEM_WAIT, and the counter saturates.
- Counters:
  - stall_cnt increments on each edge where stall_f || freeze.
  - flush_cnt increments on each edge where flush_d.
  - Both saturate at all-ones and never wrap.
- Latency: all control outputs are combinational and take effect at the same edge; counters and mem_timeout update one edge later.
- Reset mid-MEM_WAIT: returns to RUN immediately; the wait count is discarded.

Test Plan:
- Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 → forward_a_e=10. Then set rd_m=0 → forward_a_e=01. Then set rs1_e=0 → forward_a_e=00.
- Load-use: result_src_e=01, rd_e=7, rs2_d=7, pc_src_e=0 → stall_f=stall_d=flush_e=1, flush_d=0; stall_cnt=1 on the next cycle.
- Simultaneous load-use and branch: same as the load-use case plus pc_src_e=1 → stall_f=stall_d=0, flush_d=flush_e=1; flush_cnt increments by 1.
- Memory wait: mem_req_m=1, mem_ready=0 for 3 cycles, then 1.
  - freeze=1 for 3 cycles, with no flush even if pc_src_e=1.
  - FSM returns to RUN.
  - stall_cnt increases by 3.
- Watchdog: MEM_TIMEOUT=4, mem_ready held at 0 → mem_timeout=1 after 4 cycles in MEM_WAIT. It stays 1 after mem_ready and clears only on rst.
- Reset: assert rst asynchronously while in MEM_WAIT with counters nonzero → outputs go to reset values immediately, without waiting for a clock edge. After release: state RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall, flush and forwarding controls for a
// five-stage pipe, plus memory-wait tracking with a watchdog and perf counters.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rs1_d, rs2_d             Decode source registers
//   rs1_e, rs2_e, rd_e       Execute source/destination registers
//   result_src_e             Execute result select (2'b01 = load)
//   pc_src_e                 branch taken / jump resolved in Execute
//   rd_m, reg_write_m        Memory-stage destination and write enable
//   rd_w, reg_write_w        Writeback-stage destination and write enable
//   mem_req_m, mem_ready     data-memory request and completion
//   stall_f, stall_d         hold PC / F-D register
//   flush_d, flush_e         clear F-D register / D-E register
//   freeze                   hold every pipeline register (memory wait)
//   forward_a_e, forward_b_e ALU operand select (10 = M, 01 = W, 00 = RF)
//   mem_timeout              sticky watchdog error
//   stall_cnt, flush_cnt     saturating stall / flush cycle counters
module hazard_ctrl #(
    parameter int REG_WIDTH   = 5,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rs1_d,
    input  logic [REG_WIDTH-1:0] rs2_d,
    input  logic [REG_WIDTH-1:0] rs1_e,
    input  logic [REG_WIDTH-1:0] rs2_e,
    input  logic [REG_WIDTH-1:0] rd_e,
    input  logic [1:0]           result_src_e,
    input  logic                 pc_src_e,
    input  logic [REG_WIDTH-1:0] rd_m,
    input  logic                 reg_write_m,
    input  logic [REG_WIDTH-1:0] rd_w,
    input  logic                 reg_write_w,
    input  logic                 mem_req_m,
    input  logic                 mem_ready,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 freeze,
    output logic [1:0]           forward_a_e,
    output logic [1:0]           forward_b_e,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                 mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic branch;
    logic mem_stall;

    // Memory stage holds the youngest value, so it wins over Writeback.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_WIDTH-1:0] rs,
        input logic [REG_WIDTH-1:0] rdm,
        input logic                 wm,
        input logic [REG_WIDTH-1:0] rdw,
        input logic                 ww
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wm && (rdm != '0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (ww && (rdw != '0) && (rdw == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = (result_src_e == 2'b01) && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
        branch    = pc_src_e;
        mem_stall = mem_req_m && !mem_ready;

        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        freeze      = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;

        if (rst) begin
            // Clear the pipe while reset is held.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m,
                                  rd_w, reg_write_w);
            forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m,
                                  rd_w, reg_write_w);
            if (mem_stall) begin
                // Whole pipe holds; hazards are re-evaluated on release.
                freeze = 1'b1;
            end else begin
                // A taken branch squashes the load consumer anyway,
                // so the flush wins over the stall.
                stall_f = load_use && !branch;
                stall_d = load_use && !branch;
                flush_d = branch;
                flush_e = load_use || branch;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!freeze) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WAIT_MAX) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall_f || freeze) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (flush_d && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 7;
    localparam int MTO  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]    result_src_e;
    logic          pc_src_e, reg_write_m, reg_write_w;
    logic          mem_req_m, mem_ready;
    logic          stall_f, stall_d, flush_d, flush_e, freeze;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    int m_stall = 0;
    int m_flush = 0;
    int m_run   = 0;
    bit m_tout  = 1'b0;
    bit e_stall, e_freeze, e_flush;

    hazard_ctrl #(
        .REG_WIDTH  (RW),
        .CNT_WIDTH  (CW),
        .MEM_TIMEOUT(MTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .result_src_e(result_src_e),
        .pc_src_e    (pc_src_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .mem_req_m   (mem_req_m),
        .mem_ready   (mem_ready),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .freeze      (freeze),
        .forward_a_e (forward_a_e),
        .forward_b_e (forward_b_e),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd_ref(input int rs);
        if (reg_write_m && rd_m != 0 && int'(rd_m) == rs) return 2;
        if (reg_write_w && rd_w != 0 && int'(rd_w) == rs) return 1;
        return 0;
    endfunction

    task automatic check_all();
        bit lw, br, fz;
        int sf, fd, fe, fa, fb;
        lw = (result_src_e == 2'b01) && (rd_e != 0) &&
             (rd_e == rs1_d || rd_e == rs2_d);
        br = pc_src_e;
        fz = mem_req_m && !mem_ready;
        if (rst) begin
            sf = 0; fd = 1; fe = 1; fa = 0; fb = 0; fz = 0;
        end else begin
            fa = fwd_ref(int'(rs1_e));
            fb = fwd_ref(int'(rs2_e));
            if (fz) begin
                sf = 0; fd = 0; fe = 0;
            end else begin
                sf = (lw && !br) ? 1 : 0;
                fd = br ? 1 : 0;
                fe = (lw || br) ? 1 : 0;
            end
        end
        e_stall  = (sf != 0);
        e_freeze = fz;
        e_flush  = (fd != 0);
        chk("stall_f", 32'(stall_f), 32'(sf));
        chk("stall_d", 32'(stall_d), 32'(sf));
        chk("flush_d", 32'(flush_d), 32'(fd));
        chk("flush_e", 32'(flush_e), 32'(fe));
        chk("freeze", 32'(freeze), 32'(fz));
        chk("fwd_a", 32'(forward_a_e), 32'(fa));
        chk("fwd_b", 32'(forward_b_e), 32'(fb));
        chk("stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), rst ? 32'd0 : 32'(m_flush));
        chk("mem_timeout", 32'(mem_timeout), rst ? 32'd0 : 32'(m_tout));
    endtask

    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        if (rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_tout = 1'b0;
        end else begin
            if ((e_stall || e_freeze) && m_stall < CMAX) m_stall++;
            if (e_flush && m_flush < CMAX) m_flush++;
            if (e_freeze) begin
                m_run++;
                // first freeze edge enters the wait; later ones count
                if (m_run > MTO) m_tout = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        result_src_e = 2'b00; pc_src_e = 1'b0;
        reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_req_m = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // forwarding priority
        rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
        rd_w = 5'd5; reg_write_w = 1'b1;
        #1 chk("fwd_a_mem", 32'(forward_a_e), 32'd2);
        cycle();
        rd_m = 5'd0;
        #1 chk("fwd_a_wb", 32'(forward_a_e), 32'd1);
        cycle();
        rs1_e = 5'd0;
        #1 chk("fwd_a_x0", 32'(forward_a_e), 32'd0);
        cycle();
        idle();

        // load-use
        result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
        #1 chk("lu_stall", 32'(stall_f), 32'd1);
        cycle();
        idle();
        #1 chk("lu_cnt", 32'(stall_cnt), 32'(m_stall));
        cycle();

        // load-use with branch: flush wins
        result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1'b1;
        #1 chk("lubr_stall", 32'(stall_d), 32'd0);
        cycle();
        idle();
        cycle();

        // memory wait, branch pending must not flush
        mem_req_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
        repeat (3) begin
            #1 chk("mw_flush", 32'(flush_d), 32'd0);
            cycle();
        end
        mem_ready = 1'b1;
        cycle();
        idle();
        cycle();

        // watchdog
        do_reset();
        mem_req_m = 1'b1; mem_ready = 1'b0;
        repeat (MTO + 2) cycle();
        #1 chk("wd_set", 32'(mem_timeout), 32'd1);
        mem_ready = 1'b1;
        repeat (3) cycle();
        #1 chk("wd_sticky", 32'(mem_timeout), 32'd1);

        // asynchronous reset in the middle of a wait
        mem_ready = 1'b0;
        repeat (3) cycle();
        #2 rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // counter saturation
        result_src_e = 2'b01; rd_e = 5'd3; rs1_d = 5'd3;
        repeat (CMAX + 10) cycle();
        #1 chk("stall_sat", 32'(stall_cnt), 32'(CMAX));
        idle();
        pc_src_e = 1'b1;
        repeat (CMAX + 10) cycle();
        #1 chk("flush_sat", 32'(flush_cnt), 32'(CMAX));
        idle();
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rs1_d = 5'($urandom_range(0, 3));
            rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3));
            rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3));
            rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            result_src_e = 2'($urandom_range(0, 3));
            pc_src_e     = ($urandom_range(0, 3) == 0);
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            mem_req_m    = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 249) == 0);
            cycle();
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
